// File: rtl/data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_ram_responder
// Brief    : Byte-strobed data RAM for the TinyRISC-V load/store port, with
//            a 1-cycle registered read and a post-reset zero-fill scrub.
//            Optional DATA_RAM_BYPASS_EN gives write-first same-word reads.
// Revision : 1.0
// ============================================================================
module data_ram_responder #(
   parameter int DEPTH_WORDS = 4096,
   parameter int ADDR_WIDTH  = 32,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [3:0]            wr_en_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  init_busy_o,
   output logic                  oor_o
);

   localparam int                  c_IDX_W = $clog2(DEPTH_WORDS);
   localparam int                  c_LANES = 4;
   localparam logic [c_IDX_W-1:0]  c_LAST  = c_IDX_W'(DEPTH_WORDS - 1);
   localparam logic [ADDR_WIDTH-3:0] c_DEPTH = (ADDR_WIDTH - 2)'(DEPTH_WORDS);

   typedef enum logic [0:0] {
      ST_SCRUB = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [c_IDX_W-1:0]      r_scrub_cnt, w_scrub_cnt_nxt;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0]   r_rd_data;
   logic                    r_oor;

   logic [c_IDX_W-1:0]      w_rd_idx, w_wr_idx, w_mem_idx;
   logic                    w_rd_oor, w_wr_oor, w_busy;
   logic [c_LANES-1:0]      w_mem_we;
   logic [DATA_WIDTH-1:0]   w_mem_data, w_rd_word;
   logic                    w_unused;

   assign w_rd_idx = rd_addr_i[c_IDX_W+1:2];
   assign w_wr_idx = wr_addr_i[c_IDX_W+1:2];
   assign w_rd_oor = (rd_addr_i[ADDR_WIDTH-1:2] >= c_DEPTH);
   assign w_wr_oor = (wr_addr_i[ADDR_WIDTH-1:2] >= c_DEPTH);
   assign w_unused = ^{rd_addr_i[1:0], wr_addr_i[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_SCRUB;
         r_scrub_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_scrub_cnt <= w_scrub_cnt_nxt;
      end
   end

   // The scrub and the core share the single array write port.
   always_comb begin
      w_state_nxt     = r_state;
      w_scrub_cnt_nxt = r_scrub_cnt;
      w_busy          = 1'b0;
      w_mem_we        = '0;
      w_mem_idx       = w_wr_idx;
      w_mem_data      = wr_data_i;
      case (r_state)
         ST_SCRUB: begin
            w_busy          = 1'b1;
            w_mem_we        = '1;
            w_mem_idx       = r_scrub_cnt;
            w_mem_data      = '0;
            w_scrub_cnt_nxt = r_scrub_cnt + 1'b1;
            if (r_scrub_cnt == c_LAST) begin
               w_state_nxt = ST_READY;
            end
         end
         default: begin
            if (!w_wr_oor) begin
               w_mem_we = wr_en_i;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < c_LANES; i++) begin
         if (w_mem_we[i]) begin
            r_mem[w_mem_idx][8*i +: 8] <= w_mem_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      w_rd_word = r_mem[w_rd_idx];
`ifdef DATA_RAM_BYPASS_EN
      if (w_mem_idx == w_rd_idx) begin
         for (int i = 0; i < c_LANES; i++) begin
            if (w_mem_we[i]) begin
               w_rd_word[8*i +: 8] = w_mem_data[8*i +: 8];
            end
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_data <= '0;
         r_oor     <= 1'b0;
      end else if (r_state == ST_SCRUB) begin
         r_rd_data <= '0;
         r_oor     <= 1'b0;
      end else begin
         r_rd_data <= w_rd_oor ? '0 : w_rd_word;
         r_oor     <= w_rd_oor | ((|wr_en_i) & w_wr_oor);
      end
   end

   assign rd_data_o   = r_rd_data;
   assign oor_o       = r_oor;
   assign init_busy_o = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_ram_responder
// Brief    : Randomised and directed bench for data_ram_responder against a
//            word-array reference model.
// Revision : 1.0
// ============================================================================
module tb_data_ram_responder;

   localparam int DEPTH = 4096;
`ifdef DATA_RAM_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rd_addr_i = '0;
   logic [31:0] wr_addr_i = '0;
   logic [31:0] wr_data_i = '0;
   logic [3:0]  wr_en_i   = '0;
   logic [31:0] rd_data_o;
   logic        init_busy_o;
   logic        oor_o;

   int          n_checks = 0;
   int          n_fails  = 0;
   int          scrub_left = 0;
   logic [31:0] model_mem [DEPTH];

   data_ram_responder #(
      .DEPTH_WORDS(DEPTH),
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr_i  (rd_addr_i),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .wr_en_i    (wr_en_i),
      .rd_data_o  (rd_data_o),
      .init_busy_o(init_busy_o),
      .oor_o      (oor_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
   endtask

   // Apply one cycle of inputs, advance the model, check outputs after the edge.
   task automatic step(input logic [31:0] ra, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [3:0] we);
      int unsigned ri, wi;
      bit          r_in, w_in;
      logic [31:0] old_w, merged, exp_rd;
      logic        exp_oor;
      rd_addr_i = ra; wr_addr_i = wa; wr_data_i = wd; wr_en_i = we;
      ri = ra >> 2; wi = wa >> 2;
      r_in = (ri < DEPTH); w_in = (wi < DEPTH);
      exp_rd = '0; exp_oor = 1'b0;
      if (scrub_left > 0) begin
         scrub_left--;
      end else begin
         old_w  = r_in ? model_mem[ri] : 32'h0;
         merged = w_in ? model_mem[wi] : 32'h0;
         for (int b = 0; b < 4; b++)
            if (we[b]) merged[8*b +: 8] = wd[8*b +: 8];
         if (r_in)
            exp_rd = (BYPASS && we != 0 && w_in && wi == ri) ? merged : old_w;
         exp_oor = !r_in || (we != 0 && !w_in);
         if (we != 0 && w_in) model_mem[wi] = merged;
      end
      @(posedge clk); #1;
      check("rd_data", rd_data_o, exp_rd);
      check("oor", {31'b0, oor_o}, {31'b0, exp_oor});
      check("busy", {31'b0, init_busy_o}, {31'b0, scrub_left > 0});
   endtask

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       rand_addr = $urandom | 32'h0001_0000;
         1:       rand_addr = 32'h3FFC | 32'($urandom_range(0, 3));
         2:       rand_addr = 32'h4000 | 32'($urandom_range(0, 3));
         default: rand_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic rand_step();
      logic [31:0] ra, wa;
      ra = rand_addr();
      wa = ($urandom_range(0, 3) == 0) ? ra : rand_addr();
      step(ra, wa, $urandom, 4'($urandom));
   endtask

   task automatic reset_hold();
      check("rst_rd_data", rd_data_o, 32'h0);
      check("rst_busy", {31'b0, init_busy_o}, 32'h1);
      check("rst_oor", {31'b0, oor_o}, 32'h0);
   endtask

   initial begin
      #(2_000_000);
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails + 1);
      $fatal(1);
   end

   initial begin
      // Reset, then scrub with random traffic the DUT must ignore
      repeat (3) @(posedge clk);
      #1 reset_hold();
      @(negedge clk) rst = 1'b0;
      scrub_left = DEPTH;
      model_clear();
      for (int i = 0; i < DEPTH; i++) rand_step();
      check("busy_done", {31'b0, init_busy_o}, 32'h0);

      step(32'h0, 32'h0, 32'h0, 4'h0);      check("rd_0", rd_data_o, 32'h0);
      step(32'h3FFC, 32'h0, 32'h0, 4'h0);   check("rd_3ffc", rd_data_o, 32'h0);

      step(32'h0, 32'h10, 32'h11223344, 4'b1111);
      step(32'h0, 32'h10, 32'hAABBCCDD, 4'b0101);
      step(32'h10, 32'h0, 32'h0, 4'h0);     check("partial", rd_data_o, 32'h11BB33DD);

      step(32'h20, 32'h20, 32'hDEADBEEF, 4'b1111);
      check("same_word", rd_data_o, BYPASS ? 32'hDEADBEEF : 32'h0);
      step(32'h20, 32'h0, 32'h0, 4'h0);     check("same_next", rd_data_o, 32'hDEADBEEF);

      step(32'h0, 32'h4000, 32'h12345678, 4'b1111);
      check("oor_wr", {31'b0, oor_o}, 32'h1);
      step(32'h0, 32'h0, 32'h0, 4'h0);      check("oor_clear", {31'b0, oor_o}, 32'h0);
      check("oor_word0", rd_data_o, 32'h0);
      step(32'h4000, 32'h0, 32'h0, 4'h0);   check("oor_rd", {31'b0, oor_o}, 32'h1);
      check("oor_rd_data", rd_data_o, 32'h0);
      step(32'h4000, 32'h4004, 32'h1, 4'h1); check("oor_both", {31'b0, oor_o}, 32'h1);

      step(32'h40, 32'h0, 32'h1, 4'hF);
      step(32'h40, 32'h4, 32'h2, 4'hF);
      step(32'h40, 32'h8, 32'h3, 4'hF);
      step(32'h0, 32'h0, 32'h0, 4'h0);      check("b2b_0", rd_data_o, 32'h1);
      step(32'h4, 32'h0, 32'h0, 4'h0);      check("b2b_1", rd_data_o, 32'h2);
      step(32'h8, 32'h0, 32'h0, 4'h0);      check("b2b_2", rd_data_o, 32'h3);

      for (int i = 0; i < 2000; i++) rand_step();

      // Restart the scrub, then interrupt it at count 100
      rst = 1'b1;
      @(posedge clk); #1 reset_hold();
      @(negedge clk) rst = 1'b0;
      scrub_left = DEPTH;
      for (int i = 0; i < 100; i++) rand_step();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset_hold();
      @(negedge clk) rst = 1'b0;
      scrub_left = DEPTH;
      model_clear();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 5) step(32'h0, 32'h8, 32'hFFFFFFFF, 4'hF);
         else        step(32'h8, 32'h0, 32'h0, 4'h0);
      end
      step(32'h8, 32'h0, 32'h0, 4'h0);      check("scrub_drop", rd_data_o, 32'h0);
      for (int i = 0; i < 500; i++) rand_step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
`default_nettype wire
